// File: rtl/safe_alu_pipe.sv
// safe_alu_pipe: two-stage valid/ready ALU pipeline.
//   S1 registers the accepted operands; S2 registers the result and flags.
//   ADD/SUB/ADC/SBB/CMP run on WIDTH+1-bit arithmetic. A carry/borrow register
//   (carry_q) chains ADC/SBB sequences. ovf_sticky latches any delivered overflow.
// Optional feature macro: SAFE_ALU_SAT_EN. When it is defined, per-beat signed
// saturation applies to arithmetic results. When it is undefined, sat is
// ignored and results wrap.
module safe_alu_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       opcode,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             negative,
    input  logic             clr_sticky,
    output logic             ovf_sticky
);
    localparam int MSB = WIDTH - 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_ADC = 3'b101;
    localparam logic [2:0] OP_SBB = 3'b110;
    localparam logic [2:0] OP_CMP = 3'b111;

    // Stage 1: accepted operands
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [2:0]       s1_op_q, s1_op_d;
    logic             s1_sat_q, s1_sat_d;

    // Stage 2: result beat
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d, cflag_q, cflag_d;
    logic             ovf_q, ovf_d, neg_q, neg_d;

    // Architectural state
    logic             carry_q, carry_d;
    logic             ovf_sticky_q, ovf_sticky_d;

    // Handshake
    logic en1, en2, accept, advance, deliver;

    // ALU intermediates
    logic [WIDTH:0]   ext_a, ext_b, ext_c, raw;
    logic [WIDTH-1:0] fin;
    logic             is_arith, is_sub, alu_c, alu_v;

    assign en2        = !s2_valid_q || out_ready;
    assign en1        = !s1_valid_q || en2;
    assign in_ready   = en1;
    assign accept     = in_valid && en1;
    assign advance    = s1_valid_q && en2;
    assign deliver    = s2_valid_q && out_ready;

    assign out_valid  = s2_valid_q;
    assign result     = res_q;
    assign zero       = zero_q;
    assign carry      = cflag_q;
    assign overflow   = ovf_q;
    assign negative   = neg_q;
    assign ovf_sticky = ovf_sticky_q;

    // ALU: compute result and flags for the beat sitting in S1
    always_comb begin
        ext_a    = {1'b0, s1_a_q};
        ext_b    = {1'b0, s1_b_q};
        ext_c    = {{WIDTH{1'b0}}, carry_q};
        raw      = '0;
        is_arith = 1'b1;
        is_sub   = 1'b0;
        case (s1_op_q)
            OP_ADD: raw = ext_a + ext_b;
            OP_SUB: begin raw = ext_a - ext_b;          is_sub = 1'b1; end
            OP_AND: begin raw = {1'b0, s1_a_q & s1_b_q}; is_arith = 1'b0; end
            OP_OR:  begin raw = {1'b0, s1_a_q | s1_b_q}; is_arith = 1'b0; end
            OP_XOR: begin raw = {1'b0, s1_a_q ^ s1_b_q}; is_arith = 1'b0; end
            OP_ADC: raw = ext_a + ext_b + ext_c;
            OP_SBB: begin raw = ext_a - ext_b - ext_c;  is_sub = 1'b1; end
            default: begin raw = ext_a - ext_b;         is_sub = 1'b1; end // CMP
        endcase
        // Bit WIDTH is the carry for adds and the borrow for subtracts
        alu_c = is_arith && raw[WIDTH];
        alu_v = is_arith
                && (is_sub ? (s1_a_q[MSB] != s1_b_q[MSB]) : (s1_a_q[MSB] == s1_b_q[MSB]))
                && (raw[MSB] != s1_a_q[MSB]);
        fin   = (s1_op_q == OP_CMP) ? s1_a_q : raw[MSB:0];
`ifdef SAFE_ALU_SAT_EN
        // CMP returns operand a rather than the difference, so it is never clamped
        if (s1_sat_q && alu_v && (s1_op_q != OP_CMP))
            fin = s1_a_q[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    end

`ifndef SAFE_ALU_SAT_EN
    logic unused_sat;
    assign unused_sat = s1_sat_q;
`endif

    // Next-state for both pipeline stages, carry chain and sticky overflow
    always_comb begin
        s1_valid_d = en1 ? in_valid : s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        s1_sat_d   = s1_sat_q;
        if (accept) begin
            s1_a_d   = a;
            s1_b_d   = b;
            s1_op_d  = opcode;
            s1_sat_d = sat;
        end

        s2_valid_d = en2 ? s1_valid_q : s2_valid_q;
        res_d      = res_q;
        zero_d     = zero_q;
        cflag_d    = cflag_q;
        ovf_d      = ovf_q;
        neg_d      = neg_q;
        if (advance) begin
            res_d   = fin;
            zero_d  = (fin == '0);
            cflag_d = alu_c;
            ovf_d   = alu_v;
            neg_d   = fin[MSB];
        end

        // Logic ops leave the carry chain untouched
        carry_d = (advance && is_arith) ? alu_c : carry_q;

        // A set on the same cycle as a clear wins
        ovf_sticky_d = (deliver && ovf_q) || (ovf_sticky_q && !clr_sticky);
    end

    // State registers, all cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_op_q      <= '0;
            s1_sat_q     <= 1'b0;
            s2_valid_q   <= 1'b0;
            res_q        <= '0;
            zero_q       <= 1'b0;
            cflag_q      <= 1'b0;
            ovf_q        <= 1'b0;
            neg_q        <= 1'b0;
            carry_q      <= 1'b0;
            ovf_sticky_q <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_op_q      <= s1_op_d;
            s1_sat_q     <= s1_sat_d;
            s2_valid_q   <= s2_valid_d;
            res_q        <= res_d;
            zero_q       <= zero_d;
            cflag_q      <= cflag_d;
            ovf_q        <= ovf_d;
            neg_q        <= neg_d;
            carry_q      <= carry_d;
            ovf_sticky_q <= ovf_sticky_d;
        end
    end

endmodule

// File: tb/tb_safe_alu_pipe.sv
// Bench for safe_alu_pipe at WIDTH=8: directed vector table, stall/reset
// sequences, and randomized traffic against an arithmetic reference model.
module tb_safe_alu_pipe;
    localparam int W = 8;
`ifdef SAFE_ALU_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0;
    logic in_valid = 1'b0, in_ready, sat = 1'b0, out_valid, out_ready = 1'b0;
    logic zero, carry, overflow, negative, clr_sticky = 1'b0, ovf_sticky;
    logic [W-1:0] a = '0, b = '0, result;
    logic [2:0] opcode = '0;

    always #5 clk = ~clk;

    safe_alu_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .opcode(opcode), .sat(sat), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .carry(carry),
        .overflow(overflow), .negative(negative), .clr_sticky(clr_sticky),
        .ovf_sticky(ovf_sticky)
    );

    typedef struct {
        logic [W-1:0] res;
        logic z, c, v, n;
        int acc;
    } exp_t;

    typedef struct {
        logic [2:0] op;
        logic [W-1:0] a, b, res;
        logic z, c, v, n;
    } vec_t;

    int npass = 0, ntot = 0, cyc = 0, acc_cnt = 0, dlv_cnt = 0;
    exp_t expq[$];
    logic mcq = 1'b0, mstk = 1'b0;
    bit tbl_mode = 1'b0, lat_chk = 1'b0;
    exp_t cur_exp;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] expv);
        ntot++;
        if (got === expv) npass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, expv);
    endtask

    // Reference: plain integer arithmetic plus the signed-overflow rules
    function automatic exp_t ref_op(input logic [2:0] op, input logic [W-1:0] x,
                                    input logic [W-1:0] y, input logic s, input logic cin);
        exp_t e;
        int r;
        bit sub, arith;
        logic [W-1:0] raw, mx;
        arith = 1'b1; sub = 1'b0; r = 0;
        case (op)
            3'd0: r = int'(x) + int'(y);
            3'd1: begin r = int'(x) - int'(y); sub = 1'b1; end
            3'd2: begin r = int'(x & y); arith = 1'b0; end
            3'd3: begin r = int'(x | y); arith = 1'b0; end
            3'd4: begin r = int'(x ^ y); arith = 1'b0; end
            3'd5: r = int'(x) + int'(y) + int'(cin);
            3'd6: begin r = int'(x) - int'(y) - int'(cin); sub = 1'b1; end
            default: begin r = int'(x) - int'(y); sub = 1'b1; end
        endcase
        raw   = r[W-1:0];
        e.c   = arith && (sub ? (r < 0) : (r >= (1 << W)));
        e.v   = arith && (sub ? (x[W-1] != y[W-1]) : (x[W-1] == y[W-1])) && (raw[W-1] != x[W-1]);
        e.res = (op == 3'd7) ? x : raw;
        if (SAT_EN && s && e.v && op != 3'd7) begin
            mx = '1; mx[W-1] = 1'b0;
            e.res = x[W-1] ? ~mx : mx;
        end
        e.z   = (e.res == '0);
        e.n   = e.res[W-1];
        e.acc = 0;
        return e;
    endfunction

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 4))
            0: v = '0;
            1: begin v = '1; v[W-1] = 1'b0; end
            2: begin v = '0; v[W-1] = 1'b1; end
            3: v = '1;
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    always @(posedge clk) cyc++;

    // Monitor: occupancy-based in_ready, in-order scoreboard, sticky model
    always @(negedge clk) begin
        exp_t e;
        logic st;
        if (!rst_n) begin
            expq.delete();
            mcq  = 1'b0;
            mstk = 1'b0;
        end else begin
            st = 1'b0;
            chk("in_ready", in_ready, !(expq.size() >= 2 && !out_ready));
            if (out_valid && out_ready) begin
                dlv_cnt++;
                if (expq.size() == 0) begin
                    ntot++;
                    $display("FAIL spurious_beat: got result %0h, expected no beat", result);
                end else begin
                    e = expq.pop_front();
                    chk("beat", {result, zero, carry, overflow, negative},
                        {e.res, e.z, e.c, e.v, e.n});
                    if (lat_chk) chk("latency", cyc - e.acc, 2);
                    st = e.v;
                end
            end
            chk("ovf_sticky", ovf_sticky, mstk);
            mstk = st || (mstk && !clr_sticky);
            if (in_valid && in_ready) begin
                acc_cnt++;
                e = ref_op(opcode, a, b, sat, mcq);
                if (!(opcode inside {3'd2, 3'd3, 3'd4})) mcq = e.c;
                if (tbl_mode) e = cur_exp;
                e.acc = cyc;
                expq.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        bit ok;
        ok = 1'b0;
        opcode = op; a = x; b = y; sat = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk); ok = in_ready;
            step();
        end
        in_valid = 1'b0;
        if (!ok) begin ntot++; $display("FAIL send_timeout: got no in_ready, expected acceptance"); end
    endtask

    task automatic drain(input string nm);
        int k;
        k = 0;
        while (expq.size() != 0 && k < 100) begin step(); k++; end
        if (expq.size() != 0) begin
            ntot++;
            $display("FAIL %s_drain: got %0d beats outstanding, expected 0", nm, expq.size());
        end
        step(); step();
    endtask

    vec_t tv[18];

    initial begin
        int a0, d0;
        logic [W+3:0] hold;
        bit have;
        tv[0]  = '{3'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1};
        tv[1]  = '{3'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        tv[2]  = '{3'd5, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[3]  = '{3'd1, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b1};
        tv[4]  = '{3'd6, 8'h10, 8'h01, 8'h0E, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[5]  = '{3'd7, 8'h05, 8'h05, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[6]  = '{3'd7, 8'h03, 8'h05, 8'h03, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[7]  = '{3'd5, 8'h01, 8'h01, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[8]  = '{3'd2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[9]  = '{3'd3, 8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1};
        tv[10] = '{3'd4, 8'hAA, 8'hAA, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[11] = '{3'd1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0};
        tv[12] = '{3'd0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
        tv[13] = '{3'd2, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[14] = '{3'd5, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[15] = '{3'd6, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[16] = '{3'd6, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1};
        tv[17] = '{3'd6, 8'h05, 8'h00, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset state
        #2;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_outputs", {result, zero, carry, overflow, negative, ovf_sticky}, '0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // Directed table, back-to-back with out_ready high
        tbl_mode = 1'b1; lat_chk = 1'b1; out_ready = 1'b1;
        a0 = acc_cnt; d0 = dlv_cnt;
        for (int i = 0; i < 18; i++) begin
            opcode = tv[i].op; a = tv[i].a; b = tv[i].b; sat = 1'b0; in_valid = 1'b1;
            cur_exp.res = tv[i].res; cur_exp.z = tv[i].z; cur_exp.c = tv[i].c;
            cur_exp.v = tv[i].v; cur_exp.n = tv[i].n; cur_exp.acc = 0;
            step();
        end
        in_valid = 1'b0;
        drain("table");
        chk("table_accepted", acc_cnt - a0, 18);
        chk("table_delivered", dlv_cnt - d0, 18);
        tbl_mode = 1'b0; lat_chk = 1'b0;

        // Five beats against a four-cycle output stall
        out_ready = 1'b0;
        a0 = acc_cnt; d0 = dlv_cnt; have = 1'b0; hold = '0;
        fork
            begin
                for (int k = 0; k < 5; k++) send(3'd0, 8'h11 * W'(k + 1), 8'h70);
            end
            begin
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        if (have) chk("stall_hold", {result, zero, carry, overflow, negative}, hold);
                        else begin hold = {result, zero, carry, overflow, negative}; have = 1'b1; end
                    end
                end
                chk("stall_in_ready", in_ready, 1'b0);
                chk("stall_out_valid", out_valid, 1'b1);
                chk("stall_accepted", acc_cnt - a0, 2);
                step();
                out_ready = 1'b1;
            end
        join
        drain("stall");
        chk("stall_delivered", dlv_cnt - d0, 5);

        // Reset with both stages full
        send(3'd0, 8'h7F, 8'h01);
        drain("preset");
        out_ready = 1'b0;
        send(3'd0, 8'h12, 8'h34);
        send(3'd1, 8'h80, 8'h01);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_outputs", {result, zero, carry, overflow, negative, ovf_sticky}, '0);
        step();
        rst_n = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("postrst_idle", out_valid, 1'b0);
        end
        step();

        // Randomized traffic against the reference model
        for (int k = 0; k < 1500; k++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 9) < 7);
            opcode     = 3'($urandom);
            a          = pick();
            b          = pick();
            sat        = 1'($urandom);
            clr_sticky = ($urandom_range(0, 15) == 0);
            step();
        end
        in_valid = 1'b0; clr_sticky = 1'b0; out_ready = 1'b1;
        drain("random");

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
